// File: rtl/reg_bank_ext.sv
// -----------------------------------------------------------------------------
// reg_bank_ext
//
// A bank of NREG registers, each WIDTH bits wide, with a small single-operand
// ALU in front of the write port. One register (sel) can be updated per clock
// according to fun_sel. A shared zero/carry flag pair reports the status of
// the last operation that actually executed. Two independent combinational
// read ports expose any register, and out-of-range indices read as zero.
//
// Parameters
//   WIDTH  data width of every register (2..32)
//   NREG   number of registers (2..16)
//   SAT    0 = increment/decrement wrap, 1 = increment/decrement saturate
//   SW     select width, $clog2(NREG)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset: registers -> 0, zero -> 1, carry -> 0
//   en       operation enable
//   sel      index of the register written by the operation
//   fun_sel  operation code (hold, clear, load, inc, dec, shl, shr, rol)
//   data_in  load value
//   rsel_a   read port A register index
//   rsel_b   read port B register index
//   out_a    read port A data (combinational)
//   out_b    read port B data (combinational)
//   zero     1 when the last executed operation produced 0
//   carry    carry/borrow/shifted-out bit of the last executed operation
// -----------------------------------------------------------------------------
module reg_bank_ext #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int SAT   = 0,
    parameter int SW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SW-1:0]    sel,
    input  logic [2:0]       fun_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SW-1:0]    rsel_a,
    input  logic [SW-1:0]    rsel_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             zero,
    output logic             carry
);

    // -------------------------------------------------------------------------
    // Operation codes
    // -------------------------------------------------------------------------
    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_ROL   = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] reg_q [NREG];
    logic [WIDTH-1:0] reg_d [NREG];
    logic             zero_q;
    logic             zero_d;
    logic             carry_q;
    logic             carry_d;

    // -------------------------------------------------------------------------
    // Execute qualification
    // -------------------------------------------------------------------------
    // sel is SW bits wide, so when NREG is not a power of two it can name a
    // register that does not exist; such requests are silently dropped.
    logic sel_in_range;
    logic exec;

    assign sel_in_range = (32'(sel) < 32'(NREG));
    assign exec         = en && (fun_sel != OP_HOLD) && sel_in_range;

    // One-hot write enable, one bit per physical register.
    logic [NREG-1:0] wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_en
            assign wr_en[gi] = exec && (sel == SW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Operand fetch
    // -------------------------------------------------------------------------
    // Mux built as a loop over existing registers so an out-of-range sel never
    // indexes past the end of the array; it simply yields zero (and exec is
    // low in that case anyway).
    logic [WIDTH-1:0] cur_val;

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == SW'(i)) begin
                cur_val = reg_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] res_val;
    logic             res_carry;
    logic             cur_all_ones;
    logic             cur_is_zero;

    assign cur_all_ones = (cur_val == ALL_ONES);
    assign cur_is_zero  = (cur_val == '0);

    always_comb begin
        res_val   = cur_val;
        res_carry = 1'b0;
        case (fun_sel)
            OP_CLEAR: begin
                res_val   = '0;
                res_carry = 1'b0;
            end
            OP_LOAD: begin
                res_val   = data_in;
                res_carry = 1'b0;
            end
            OP_INC: begin
                // Carry flags the overflow condition in both modes; in
                // saturating mode the value is pinned at all ones instead of
                // wrapping to zero.
                res_carry = cur_all_ones;
                if ((SAT != 0) && cur_all_ones) begin
                    res_val = cur_val;
                end else begin
                    res_val = cur_val + ONE;
                end
            end
            OP_DEC: begin
                // Carry doubles as borrow here.
                res_carry = cur_is_zero;
                if ((SAT != 0) && cur_is_zero) begin
                    res_val = '0;
                end else begin
                    res_val = cur_val - ONE;
                end
            end
            OP_SHL: begin
                res_val   = {cur_val[WIDTH-2:0], 1'b0};
                res_carry = cur_val[WIDTH-1];
            end
            OP_SHR: begin
                res_val   = {1'b0, cur_val[WIDTH-1:1]};
                res_carry = cur_val[0];
            end
            OP_ROL: begin
                res_val   = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
                res_carry = cur_val[WIDTH-1];
            end
            default: begin
                // OP_HOLD: never executes, values irrelevant.
                res_val   = cur_val;
                res_carry = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            reg_d[i] = wr_en[i] ? res_val : reg_q[i];
        end
    end

    // Flags only move on an executed operation; idle cycles keep the status
    // of whatever last ran.
    assign zero_d  = exec ? (res_val == '0) : zero_q;
    assign carry_d = exec ? res_carry       : carry_q;

    // -------------------------------------------------------------------------
    // Registers (reset wins over any operation on the same edge)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= reg_d[i];
            end
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    // Purely combinational from the registered state, so a register being
    // written shows its old value until the edge. Indices past NREG-1 read 0.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rsel_a == SW'(i)) begin
                out_a = reg_q[i];
            end
            if (rsel_b == SW'(i)) begin
                out_b = reg_q[i];
            end
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;

endmodule
